image_line_feeder: RTL and testbench

IMAGE_LINE_FEEDER -- requirements
Module: image_line_feeder

---
 rtl/image_line_feeder.sv | 165 ++++++++++++++++
 tb/tb_image_line_feeder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_line_feeder.sv
// Streams a frame from pixel memory to a line-buffer consumer: primes 4 lines, then one line per intr.
// Define IMAGE_FEEDER_BOTTOM_PAD_EN to append 2 zero-filled bottom pad lines before DRAIN.
module image_line_feeder #(
    parameter int IMG_W  = 512,
    parameter int IMG_H  = 512,
    parameter int ADDR_W = 18
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic              i_intr,
    output logic              o_mem_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [7:0]        i_mem_data,
    output logic [7:0]        o_pixel_data,
    output logic              o_data_valid,
    output logic              o_busy,
    output logic              o_done
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H + 1);
    localparam logic [COL_W-1:0] COL_PENULT = COL_W'(IMG_W - 2);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] PRIME_LAST = ROW_W'(3);

    typedef enum logic [2:0] {IDLE, PRIME, WAIT_INTR, LINE, PAD, DRAIN} state_t;

    state_t            state_q;
    logic [ROW_W-1:0]  row_q;
    logic [COL_W-1:0]  col_q;
    logic [1:0]        pend_q, pend_d;
    logic              mem_en_q, pad_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              vld1_q, zero1_q, valid_q;
    logic [7:0]        pixel_q;
    logic              busy_q, done_q;
    logic              row_last, line_start, intr_ok, pad_left;

`ifdef IMAGE_FEEDER_BOTTOM_PAD_EN
    logic [1:0] pad_cnt_q;
    assign pad_left = (pad_cnt_q != 2'd2);

    always_ff @(posedge i_clk) begin
        if (i_rst || state_q == IDLE)
            pad_cnt_q <= 2'd0;
        else if (state_q == PAD && col_q == COL_PENULT)
            pad_cnt_q <= pad_cnt_q + 2'd1;
    end
`else
    assign pad_left = 1'b0;
`endif

    // row_q/col_q always hold the coordinates of the most recently issued read (or pad pixel).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        row_last   = (row_q == ROW_LAST);
        line_start = (state_q == WAIT_INTR) && (pend_q != 2'd0) && (!row_last || pad_left);
        intr_ok    = i_intr && (state_q != IDLE) && (state_q != DRAIN);
        pend_d     = pend_q;
        if (intr_ok && !line_start)
            pend_d = (pend_q == 2'd3) ? 2'd3 : pend_q + 2'd1;
        else if (!intr_ok && line_start)
            pend_d = pend_q - 2'd1;
    end

    // NOTE: sequential state uses non-blocking assignments only; later assignments in the block win.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            pend_q     <= 2'd0;
            mem_en_q   <= 1'b0;
            pad_q      <= 1'b0;
            mem_addr_q <= '0;
            vld1_q     <= 1'b0;
            zero1_q    <= 1'b0;
            valid_q    <= 1'b0;
            pixel_q    <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            done_q   <= 1'b0;
            mem_en_q <= 1'b0;
            pad_q    <= 1'b0;
            // Two-stage return path: memory latency, then the output register.
            vld1_q   <= mem_en_q | pad_q;
            zero1_q  <= pad_q;
            valid_q  <= vld1_q;
            pixel_q  <= (vld1_q && !zero1_q) ? i_mem_data : 8'h00;

            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        state_q    <= PRIME;
                        busy_q     <= 1'b1;
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= i_base_addr;
                        row_q      <= '0;
                        col_q      <= '0;
                        pend_q     <= 2'd0;
                    end
                end
                PRIME: begin
                    mem_en_q   <= 1'b1;
                    mem_addr_q <= mem_addr_q + ADDR_W'(1);
                    col_q      <= col_q + COL_W'(1);
                    if (col_q == COL_W'(IMG_W - 1))
                        row_q <= row_q + ROW_W'(1);
                    if (row_q == PRIME_LAST && col_q == COL_PENULT)
                        state_q <= WAIT_INTR;
                end
                WAIT_INTR: begin
                    // The first read of the next line issues here so consecutive lines abut.
                    if (line_start) begin
                        col_q <= '0;
                        if (!row_last) begin
                            state_q    <= LINE;
                            mem_en_q   <= 1'b1;
                            mem_addr_q <= mem_addr_q + ADDR_W'(1);
                            row_q      <= row_q + ROW_W'(1);
                        end else begin
                            state_q <= PAD;
                            pad_q   <= 1'b1;
                        end
                    end else if (row_last && !pad_left) begin
                        state_q <= DRAIN;
                    end
                end
                LINE: begin
                    mem_en_q   <= 1'b1;
                    mem_addr_q <= mem_addr_q + ADDR_W'(1);
                    col_q      <= col_q + COL_W'(1);
                    if (col_q == COL_PENULT)
                        state_q <= WAIT_INTR;
                end
                PAD: begin
                    pad_q <= 1'b1;
                    col_q <= col_q + COL_W'(1);
                    if (col_q == COL_PENULT)
                        state_q <= WAIT_INTR;
                end
                DRAIN: begin
                    if (!mem_en_q && !vld1_q && !valid_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_mem_en     = mem_en_q;
    assign o_mem_addr   = mem_addr_q;
    assign o_pixel_data = pixel_q;
    assign o_data_valid = valid_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

endmodule

// File: tb/tb_image_line_feeder.sv
// Bench for image_line_feeder: scenario table with a pixel scoreboard and address tracker,
// plus hand-written reset sequences. Memory model returns addr[7:0] one cycle after o_mem_en.
module tb_image_line_feeder;

    localparam int IMG_W  = 512;
    localparam int IMG_H  = 8;
    localparam int ADDR_W = 18;
`ifdef IMAGE_FEEDER_BOTTOM_PAD_EN
    localparam int PAD_LINES = 2;
`else
    localparam int PAD_LINES = 0;
`endif

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_start = 1'b0;
    logic              i_intr = 1'b0;
    logic [ADDR_W-1:0] i_base_addr = '0;
    logic [7:0]        i_mem_data = 8'h00;
    logic              o_mem_en, o_data_valid, o_busy, o_done;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [7:0]        o_pixel_data;

    image_line_feeder #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_base_addr  (i_base_addr),
        .i_intr       (i_intr),
        .o_mem_en     (o_mem_en),
        .o_mem_addr   (o_mem_addr),
        .i_mem_data   (i_mem_data),
        .o_pixel_data (o_pixel_data),
        .o_data_valid (o_data_valid),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) i_mem_data <= o_mem_en ? o_mem_addr[7:0] : 8'hA5;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [ADDR_W-1:0] base;
        int                prime_intr;
        int                after_intr;
        int                exp_valid;
        int                exp_reads;
        logic [ADDR_W-1:0] exp_last;
        int                exp_gaps;   // -1: not checked
        int                exp_done;
    } vec_t;

    vec_t vecs[6];

    int n_tests = 0, n_fail = 0;
    logic [7:0] exp_q[$];
    int valid_cnt, read_cnt, pix_err, addr_err, gaps, done_cnt;
    int first_en_cyc, first_valid_cyc, last_valid_cyc, done_cyc;
    logic [ADDR_W-1:0] exp_addr, last_addr;
    int model_rows, model_pads;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_mem_en) begin
                if (o_mem_addr !== exp_addr) addr_err++;
                exp_addr = exp_addr + ADDR_W'(1);
                last_addr = o_mem_addr;
                if (first_en_cyc < 0) first_en_cyc = cyc;
                read_cnt++;
            end
            if (o_data_valid) begin
                if (exp_q.size() == 0) pix_err++;
                else if (exp_q.pop_front() !== o_pixel_data) pix_err++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (last_valid_cyc >= 0 && cyc - last_valid_cyc > 1) gaps += cyc - last_valid_cyc - 1;
                last_valid_cyc = cyc;
                valid_cnt++;
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_stats();
        exp_q.delete();
        valid_cnt = 0; read_cnt = 0; pix_err = 0; addr_err = 0; gaps = 0; done_cnt = 0;
        first_en_cyc = -1; first_valid_cyc = -1; last_valid_cyc = -1; done_cyc = -1;
        last_addr = '0;
    endtask

    task automatic push_row(input logic [ADDR_W-1:0] base, input int row);
        for (int c = 0; c < IMG_W; c++) begin
            logic [ADDR_W-1:0] a;
            a = base + ADDR_W'(row * IMG_W + c);
            exp_q.push_back(a[7:0]);
        end
    endtask

    task automatic push_pad();
        for (int c = 0; c < IMG_W; c++) exp_q.push_back(8'h00);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic pulse_intr();
        i_intr = 1'b1;
        @(negedge i_clk);
        i_intr = 1'b0;
    endtask

    task automatic start_frame(input logic [ADDR_W-1:0] base);
        i_base_addr = base;
        exp_addr    = base;
        for (int r = 0; r < 4; r++) push_row(base, r);
        model_rows = 4;
        model_pads = 0;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int pr;
        start_frame(v.base);
        check($sformatf("v%0d_busy_start", idx), int'(o_busy), 1);
        repeat (9) @(negedge i_clk);
        // A second start while busy must not disturb the running frame.
        i_base_addr = 18'h2AAAA;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        for (int k = 0; k < v.prime_intr; k++) begin
            if (k < 3) begin
                push_row(v.base, model_rows);
                model_rows++;
            end
            pulse_intr();
        end
        pr = (v.prime_intr < 3) ? v.prime_intr : 3;
        repeat ((4 + pr) * IMG_W + 10) @(negedge i_clk);
        for (int k = 0; k < v.after_intr; k++) begin
            if (model_rows < IMG_H) begin
                push_row(v.base, model_rows);
                model_rows++;
            end else if (model_pads < PAD_LINES) begin
                push_pad();
                model_pads++;
            end
            pulse_intr();
            repeat (IMG_W + 10) @(negedge i_clk);
        end
        repeat (10) @(negedge i_clk);

        check($sformatf("v%0d_valid_cnt", idx), valid_cnt, v.exp_valid);
        check($sformatf("v%0d_read_cnt", idx), read_cnt, v.exp_reads);
        check($sformatf("v%0d_pixel_err", idx), pix_err, 0);
        check($sformatf("v%0d_leftover", idx), exp_q.size(), 0);
        check($sformatf("v%0d_addr_err", idx), addr_err, 0);
        check($sformatf("v%0d_last_addr", idx), int'(last_addr), int'(v.exp_last));
        check($sformatf("v%0d_latency", idx), first_valid_cyc - first_en_cyc, 2);
        if (v.exp_gaps >= 0) check($sformatf("v%0d_gaps", idx), gaps, v.exp_gaps);
        check($sformatf("v%0d_done_cnt", idx), done_cnt, v.exp_done);
        if (v.exp_done != 0) begin
            check($sformatf("v%0d_done_lat", idx), done_cyc - last_valid_cyc, 2);
            check($sformatf("v%0d_busy_end", idx), int'(o_busy), 0);
        end else begin
            check($sformatf("v%0d_busy_end", idx), int'(o_busy), 1);
        end
    endtask

    initial begin
        int t;
        vecs[0] = '{18'h00100, 0, 0, 2048, 2048, 18'h008FF, 0, 0};
        vecs[2] = '{18'h00100, 4, 0, 3584, 3584, 18'h00EFF, 0, 0};
        vecs[3] = '{18'h3FF00, 0, 0, 2048, 2048, 18'h006FF, 0, 0};
`ifdef IMAGE_FEEDER_BOTTOM_PAD_EN
        vecs[1] = '{18'h00100, 0, 4, 4096, 4096, 18'h010FF, -1, 0};
        vecs[4] = '{18'h00000, 3, 1, 4096, 4096, 18'h00FFF, -1, 0};
        vecs[5] = '{18'h00000, 0, 6, 5120, 4096, 18'h00FFF, -1, 1};
`else
        vecs[1] = '{18'h00100, 0, 4, 4096, 4096, 18'h010FF, -1, 1};
        vecs[4] = '{18'h00000, 3, 1, 4096, 4096, 18'h00FFF, -1, 1};
        vecs[5] = '{18'h00000, 0, 6, 4096, 4096, 18'h00FFF, -1, 1};
`endif
        clear_stats();

        // Reset held with start and intr active: everything stays quiet.
        i_rst = 1'b1; i_start = 1'b1; i_intr = 1'b1; i_base_addr = 18'h12345;
        repeat (3) @(negedge i_clk);
        check("rst_mem_en", int'(o_mem_en), 0);
        check("rst_valid", int'(o_data_valid), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_mem_addr", int'(o_mem_addr), 0);
        check("rst_pixel", int'(o_pixel_data), 0);
        i_start = 1'b0; i_intr = 1'b0; i_rst = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        check("post_rst_mem_en", int'(o_mem_en), 0);
        check("post_rst_valid", int'(o_data_valid), 0);
        check("post_rst_busy", int'(o_busy), 0);
        check("post_rst_done", int'(o_done), 0);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            clear_stats();
            run_vec(vecs[i], i);
        end

        // Abort at row 5 column 100, then restart from row 0.
        do_reset();
        clear_stats();
        start_frame(18'h00000);
        for (int k = 0; k < 3; k++) begin
            push_row(18'h00000, model_rows);
            model_rows++;
            pulse_intr();
        end
        t = 0;
        while (valid_cnt < 5 * IMG_W + 100 && t < 20000) begin
            @(posedge i_clk);
            t++;
        end
        check("abort_reach", valid_cnt, 5 * IMG_W + 100);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("abort_valid", int'(o_data_valid), 0);
        check("abort_busy", int'(o_busy), 0);
        check("abort_mem_en", int'(o_mem_en), 0);
        i_rst = 1'b0;
        clear_stats();
        repeat (10) @(negedge i_clk);
        check("abort_flushed", valid_cnt, 0);
        run_vec(vecs[0], 99);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
